// File: rtl/reg_file_sb.sv
// NREGS x WIDTH register file, two async read ports, one sync write port,
// plus a per-register pending scoreboard. Define REG_FILE_SB_BYPASS_EN for write-to-read bypass.
module reg_file_sb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddrA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB,
  output logic             BusyA,
  output logic             BusyB,
  input  logic             RsvEn,
  input  logic [AW-1:0]    RsvAddr,
  output logic [NREGS-1:0] Pending,
  output logic             Idle
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             wr_live;

  assign wr_live = WrEn && (WrAddr != '0);

  // Next state: a reservation overrides a same-cycle write-back clear; register 0 stays zero.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_live) begin
      regs_d[WrAddr]    = WrData;
      pending_d[WrAddr] = 1'b0;
    end
    if (RsvEn) begin
      pending_d[RsvAddr] = 1'b1;
    end
    regs_d[0]    = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  logic rsv_same;
  assign rsv_same = RsvEn && (RsvAddr == WrAddr);
`endif

  // Combinational read ports.
  always_comb begin
    RdDataA = (RdAddrA == '0) ? '0 : regs_q[RdAddrA];
    RdDataB = (RdAddrB == '0) ? '0 : regs_q[RdAddrB];
    BusyA   = pending_q[RdAddrA];
    BusyB   = pending_q[RdAddrB];
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_live && (RdAddrA == WrAddr)) begin
      RdDataA = WrData;
      BusyA   = rsv_same;
    end
    if (wr_live && (RdAddrB == WrAddr)) begin
      RdDataB = WrData;
      BusyB   = rsv_same;
    end
`endif
  end

  assign Pending = pending_q;
  assign Idle    = ~|pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-driven bench for reg_file_sb; honours REG_FILE_SB_BYPASS_EN when defined.
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [31:0] WrData;
  logic [3:0]  RdAddrA;
  logic [3:0]  RdAddrB;
  logic [31:0] RdDataA;
  logic [31:0] RdDataB;
  logic        BusyA;
  logic        BusyB;
  logic        RsvEn;
  logic [3:0]  RsvAddr;
  logic [15:0] Pending;
  logic        Idle;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q  [$];
  logic [15:0] pexp_q [$];

  always #5 Clk = ~Clk;

  reg_file_sb #(.WIDTH(32), .NREGS(16), .AW(4)) dut (
    .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(RdDataA), .RdDataB(RdDataB),
    .BusyA(BusyA), .BusyB(BusyB), .RsvEn(RsvEn), .RsvAddr(RsvAddr),
    .Pending(Pending), .Idle(Idle)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    Rst = 1'b0; WrEn = 1'b0; RsvEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [15:0] p;
    quiet();
    WrEn = 1'b1; WrAddr = 4'd3; WrData = 32'hDEADBEEF;
    RsvEn = 1'b1; RsvAddr = 4'd5;
    step();
    quiet();
    RdAddrA = 4'd3; RdAddrB = 4'd5;
    #1;
    checks++;
    if (RdDataA !== 32'hDEADBEEF) begin failures++; $display("FAIL reset_preload data got=%h want=%h", RdDataA, 32'hDEADBEEF); end
    checks++;
    if (BusyB !== 1'b1) begin failures++; $display("FAIL reset_preload busy got=%b want=1", BusyB); end
    Rst = 1'b1; WrEn = 1'b1; WrAddr = 4'd3; WrData = 32'h1;
    RsvEn = 1'b1; RsvAddr = 4'd7;
    exp_q.push_back(32'h0);
    pexp_q.push_back(16'h0000);
    step();
    quiet();
    #1;
    e = exp_q.pop_front();
    p = pexp_q.pop_front();
    checks++;
    if (RdDataA !== e) begin failures++; $display("FAIL reset_data got=%h want=%h", RdDataA, e); end
    checks++;
    if (Pending !== p) begin failures++; $display("FAIL reset_pending got=%h want=%h", Pending, p); end
    checks++;
    if (Idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", Idle); end
    checks++;
    if (BusyA !== 1'b0 || BusyB !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b want=00", BusyA, BusyB); end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    quiet();
    WrEn = 1'b1; WrAddr = 4'd7; WrData = 32'hFFFFFFFF;
    exp_q.push_back(32'hFFFFFFFF);
    step();
    WrAddr = 4'd2; WrData = 32'h12345678;
    exp_q.push_back(32'h12345678);
    step();
    quiet();
    RdAddrA = 4'd7; RdAddrB = 4'd2;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (RdDataA !== e) begin failures++; $display("FAIL wr_rd_a got=%h want=%h", RdDataA, e); end
    e = exp_q.pop_front();
    checks++;
    if (RdDataB !== e) begin failures++; $display("FAIL wr_rd_b got=%h want=%h", RdDataB, e); end
    checks++;
    if (Pending !== 16'h0000) begin failures++; $display("FAIL wr_unreserved_pending got=%h want=0000", Pending); end
  endtask

  task automatic test_reg0();
    quiet();
    WrEn = 1'b1; WrAddr = 4'd0; WrData = 32'hA5A5A5A5;
    RsvEn = 1'b1; RsvAddr = 4'd0;
    RdAddrA = 4'd0;
    step();
    quiet();
    #1;
    checks++;
    if (RdDataA !== 32'h0) begin failures++; $display("FAIL reg0_data got=%h want=00000000", RdDataA); end
    checks++;
    if (Pending[0] !== 1'b0) begin failures++; $display("FAIL reg0_pending got=%b want=0", Pending[0]); end
    checks++;
    if (Idle !== 1'b1) begin failures++; $display("FAIL reg0_idle got=%b want=1", Idle); end
    checks++;
    if (BusyA !== 1'b0) begin failures++; $display("FAIL reg0_busy got=%b want=0", BusyA); end
  endtask

  task automatic test_scoreboard();
    quiet();
    RsvEn = 1'b1; RsvAddr = 4'd4;
    step();
    quiet();
    RdAddrA = 4'd4;
    #1;
    checks++;
    if (Pending !== 16'h0010) begin failures++; $display("FAIL sb_rsv_pending got=%h want=0010", Pending); end
    checks++;
    if (BusyA !== 1'b1) begin failures++; $display("FAIL sb_rsv_busy got=%b want=1", BusyA); end
    checks++;
    if (Idle !== 1'b0) begin failures++; $display("FAIL sb_rsv_idle got=%b want=0", Idle); end
    // re-reserving does not count: a single write-back clears it
    RsvEn = 1'b1; RsvAddr = 4'd4;
    step();
    quiet();
    WrEn = 1'b1; WrAddr = 4'd4; WrData = 32'h55;
    step();
    quiet();
    #1;
    checks++;
    if (Pending !== 16'h0000) begin failures++; $display("FAIL sb_wb_pending got=%h want=0000", Pending); end
    checks++;
    if (RdDataA !== 32'h55) begin failures++; $display("FAIL sb_wb_data got=%h want=00000055", RdDataA); end
    checks++;
    if (Idle !== 1'b1) begin failures++; $display("FAIL sb_wb_idle got=%b want=1", Idle); end
  endtask

  task automatic test_simultaneous();
    quiet();
    RsvEn = 1'b1; RsvAddr = 4'd6;
    step();
    WrEn = 1'b1; WrAddr = 4'd6; WrData = 32'h99;
    step();
    quiet();
    RdAddrA = 4'd6;
    #1;
    checks++;
    if (Pending !== 16'h0040) begin failures++; $display("FAIL simul_pending got=%h want=0040", Pending); end
    checks++;
    if (RdDataA !== 32'h99) begin failures++; $display("FAIL simul_data got=%h want=00000099", RdDataA); end
    WrEn = 1'b1; WrAddr = 4'd6; WrData = 32'h9A;
    step();
    quiet();
    #1;
    checks++;
    if (Pending !== 16'h0000) begin failures++; $display("FAIL simul_clear got=%h want=0000", Pending); end
  endtask

  task automatic test_bypass();
    logic [31:0] e_same;
    logic        b_same;
    logic        b_rsv;
`ifdef REG_FILE_SB_BYPASS_EN
    e_same = 32'hCAFE0001; b_same = 1'b0; b_rsv = 1'b1;
`else
    e_same = 32'h0; b_same = 1'b1; b_rsv = 1'b0;
`endif
    quiet();
    RsvEn = 1'b1; RsvAddr = 4'd9;
    step();
    quiet();
    WrEn = 1'b1; WrAddr = 4'd9; WrData = 32'hCAFE0001;
    RdAddrA = 4'd9; RdAddrB = 4'd9;
    #1;
    checks++;
    if (RdDataA !== e_same) begin failures++; $display("FAIL byp_same_data got=%h want=%h", RdDataA, e_same); end
    checks++;
    if (BusyA !== b_same) begin failures++; $display("FAIL byp_same_busy got=%b want=%b", BusyA, b_same); end
    checks++;
    if (RdDataB !== e_same) begin failures++; $display("FAIL byp_same_data_b got=%h want=%h", RdDataB, e_same); end
    step();
    quiet();
    #1;
    checks++;
    if (RdDataA !== 32'hCAFE0001) begin failures++; $display("FAIL byp_next_data got=%h want=cafe0001", RdDataA); end
    checks++;
    if (BusyA !== 1'b0) begin failures++; $display("FAIL byp_next_busy got=%b want=0", BusyA); end
    // write and reserve of a non-pending register in the same cycle
    WrEn = 1'b1; WrAddr = 4'd10; WrData = 32'h10;
    RsvEn = 1'b1; RsvAddr = 4'd10;
    RdAddrB = 4'd10;
    #1;
    checks++;
    if (BusyB !== b_rsv) begin failures++; $display("FAIL byp_rsv_busy got=%b want=%b", BusyB, b_rsv); end
    step();
    quiet();
    #1;
    checks++;
    if (BusyB !== 1'b1 || RdDataB !== 32'h10) begin failures++; $display("FAIL byp_rsv_next got=%b/%h want=1/00000010", BusyB, RdDataB); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] e;
    quiet();
    for (int i = 1; i < 16; i++) begin
      v = $urandom;
      WrEn = 1'b1; WrAddr = 4'(i); WrData = v;
      exp_q.push_back(v);
      step();
    end
    quiet();
    for (int i = 1; i < 16; i++) begin
      RdAddrA = 4'(i);
      RdAddrB = 4'(i);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (RdDataA !== e) begin failures++; $display("FAIL b2b_a[%0d] got=%h want=%h", i, RdDataA, e); end
      checks++;
      if (RdDataB !== e) begin failures++; $display("FAIL b2b_b[%0d] got=%h want=%h", i, RdDataB, e); end
    end
    // every write-back cleared its pending bit, including reg10
    checks++;
    if (Pending !== 16'h0000 || Idle !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%h/%b want=0000/1", Pending, Idle); end
  endtask

  initial begin
    Rst = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RsvEn = 1'b0; RsvAddr = '0; RdAddrA = '0; RdAddrB = '0;
    step();
    step();
    test_reset();
    test_write_read();
    test_reg0();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Register file for the datapath: NREGS x WIDTH storage, two asynchronous read ports, one synchronous write port.
- Each storage element is an enabled, synchronously reset register. The file sits between the decode/issue stage, which reads and reserves, and the write-back stage, which writes.
- An integrated scoreboard keeps one pending bit per register, so issue can stall on read-after-write hazards.

Parameters:
- WIDTH, 32, data width of every register.
- NREGS, 16, number of registers; must be a power of two, at least 2.
- AW, 4, address width; must equal log2(NREGS).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- WrEn  input  1  write-back strobe.
- WrAddr  input  AW  write-back destination.
- WrData  input  WIDTH  write-back data.
- RdAddrA  input  AW  read port A address.
- RdAddrB  input  AW  read port B address.
- RdDataA  output  WIDTH  read port A data.
- RdDataB  output  WIDTH  read port B data.
- BusyA  output  1  pending bit of RdAddrA.
- BusyB  output  1  pending bit of RdAddrB.
- RsvEn  input  1  issue-stage reservation strobe.
- RsvAddr  input  AW  register being reserved.
- Pending  output  NREGS  full scoreboard vector; bit i is the pending bit of register i.
- Idle  output  1  high when Pending is all zero.

Behaviour:
- Reset:
  - When Rst=1 at a rising edge, every register clears to 0 and every Pending bit clears to 0, regardless of WrEn and RsvEn.
  - After reset: RdDataA=RdDataB=0, BusyA=BusyB=0, Idle=1.
  - Reset takes priority over any write or reservation in the same cycle.
- Register 0:
  - Hardwired zero; reads always return 0.
  - Writes to address 0 are discarded.
  - Reservations of address 0 are discarded; Pending[0] is constant 0.
- Write:
  - With WrEn=1 and WrAddr!=0 at a rising edge, reg[WrAddr] <= WrData.
  - The write is visible on the read ports the cycle after the edge (1-cycle write latency).
- Read:
  - Combinational. RdDataX = reg[RdAddrX] and BusyX = Pending[RdAddrX], evaluated in the same cycle.
- Scoreboard, per register i≠0, at each rising edge with Rst=0:
  - RsvEn=1 and RsvAddr=i: Pending[i] <= 1.
  - Else if WrEn=1 and WrAddr=i: Pending[i] <= 0.
  - Else: Pending[i] holds.
- Simultaneous reserve and write-back to the same address: reservation wins and Pending stays 1 (new outstanding producer). The data write still happens.
- Write-back to a register that is not pending: data is written, Pending remains 0. This is legal and not flagged.
- Reserving an already-pending register: Pending stays 1. There is no counting; one write-back clears it.
- Idle is combinational: the NOR of Pending.
- Both read ports may address the same register; both return identical data and busy values.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - When WrEn=1, WrAddr!=0 and RdAddrX==WrAddr, RdDataX returns WrData combinationally in the same cycle.
  - BusyX for that port is forced to 0 in that cycle, unless RsvEn=1 with RsvAddr==WrAddr in the same cycle.
- Undefined:
  - Reads return the stored value; the new data appears one cycle later.
  - BusyX reflects the registered Pending bit only.

Test Plan:
- Reset: load reg3=32'hDEADBEEF and reserve reg5, then assert Rst=1 with WrEn=1, WrAddr=3, WrData=32'h1 for 1 cycle -> reg3 reads 0, Pending=16'h0000, Idle=1.
- Write/read: write 32'hFFFFFFFF to reg7, 32'h12345678 to reg2; read A=7, B=2 next cycle -> RdDataA=32'hFFFFFFFF, RdDataB=32'h12345678.
- Register 0: write 32'hA5A5A5A5 to reg0 and RsvEn with RsvAddr=0 -> RdDataA(addr 0)=0, Pending[0]=0, Idle=1.
- Scoreboard lifecycle:
  - Reserve reg4 -> next cycle Pending=16'h0010, BusyA(addr 4)=1, Idle=0.
  - Write-back reg4 with 32'h55 -> next cycle Pending=0, RdDataA=32'h55.
- Simultaneous events: with reg6 pending, assert RsvEn(6) and WrEn(6, 32'h99) in the same cycle -> Pending[6] stays 1 and reg6 reads 32'h99.
- Bypass: WrEn=1, WrAddr=9, WrData=32'hCAFE0001, RdAddrA=9, reg9 previously 0:
  - With REG_FILE_SB_BYPASS_EN: same-cycle RdDataA=32'hCAFE0001.
  - Without it: same-cycle RdDataA=0, next cycle 32'hCAFE0001.
